seg_scan_driver: RTL and testbench

- Downstream of the seconds-to-digit splitter. Takes four BCD digits (mm:ss) and time-multiplexes them onto a common-anode 4-digit 7-segment display.
- Owns the digit scan timing, tear-free digit update at frame boundaries, per-digit decimal point, per-digit blink (adjust mode), leading-zero blanking and an invalid-digit indicator.
- Replaces the ad-hoc digit position/decimal point logic and the separate display clock domain. Everything runs on clk with internal tick counters.

---
 rtl/seg_scan_driver.sv | 110 +++++++++++
 tb/tb_seg_scan_driver.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Scans four BCD digits (mm:ss) onto a common-anode 7-segment display with tear-free frame updates,
// per-digit dp/blink, leading-zero blanking and a dash for invalid codes. Optional: SEG_GHOST_GUARD_EN.
module seg_scan_driver #(
  parameter int SCAN_DIV     = 100000,
  parameter int BLINK_DIV    = 25000000,
  parameter int GUARD_CYCLES = 1000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] digits_in,
  input  logic        load,
  input  logic [3:0]  dp_mask,
  input  logic [3:0]  blink_mask,
  input  logic        blank_lead,
  output logic [3:0]  an,
  output logic [7:0]  seg,
  output logic        frame_done
);

  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  logic [SW-1:0] scan_cnt;
  logic [BW-1:0] blink_cnt;
  logic [1:0]    idx;
  logic          blink_phase;
  logic [15:0]   pending;
  logic [15:0]   active;
  // Display stays dark after reset until the first frame boundary commits a value.
  logic          live;

  logic          scan_tc;
  logic          blink_tc;
  logic          boundary;
  logic          in_guard;
  logic          dark;
  logic [3:0]    nib;
  logic [6:0]    seg7;
  logic [3:0]    an_d;
  logic [7:0]    seg_d;

  assign scan_tc  = (scan_cnt == SW'(SCAN_DIV - 1));
  assign blink_tc = (blink_cnt == BW'(BLINK_DIV - 1));
  assign boundary = scan_tc && (idx == 2'd3);

`ifdef SEG_GHOST_GUARD_EN
  assign in_guard = (32'(scan_cnt) < GUARD_CYCLES);
`else
  // Never true: the anode is driven for the whole slot.
  assign in_guard = (GUARD_CYCLES < 0);
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt    <= '0;
      blink_cnt   <= '0;
      idx         <= 2'd0;
      blink_phase <= 1'b0;
      pending     <= 16'h0000;
      active      <= 16'h0000;
      live        <= 1'b0;
      frame_done  <= 1'b0;
      an          <= 4'b1111;
      seg         <= 8'hFF;
    end else begin
      scan_cnt   <= scan_tc ? '0 : scan_cnt + 1'b1;
      blink_cnt  <= blink_tc ? '0 : blink_cnt + 1'b1;
      if (blink_tc) blink_phase <= ~blink_phase;
      if (scan_tc) idx <= idx + 2'd1;
      if (load) pending <= digits_in;
      if (boundary) begin
        active <= load ? digits_in : pending;
        live   <= 1'b1;
      end
      frame_done <= boundary;
      an         <= an_d;
      seg        <= seg_d;
    end
  end

  always_comb begin
    nib  = active[{idx, 2'b00} +: 4];
    seg7 = 7'h3F;
    case (nib)
      4'd0: seg7 = 7'h40;
      4'd1: seg7 = 7'h79;
      4'd2: seg7 = 7'h24;
      4'd3: seg7 = 7'h30;
      4'd4: seg7 = 7'h19;
      4'd5: seg7 = 7'h12;
      4'd6: seg7 = 7'h02;
      4'd7: seg7 = 7'h78;
      4'd8: seg7 = 7'h00;
      4'd9: seg7 = 7'h10;
      default: seg7 = 7'h3F;
    endcase

    dark = !live || in_guard || (blink_mask[idx] && blink_phase)
         || (blank_lead && (idx == 2'd3) && (active[15:12] == 4'h0))
         || (blank_lead && (idx == 2'd2) && (active[15:8] == 8'h00));

    an_d  = 4'b1111;
    seg_d = 8'hFF;
    if (!dark) begin
      an_d  = ~(4'b0001 << idx);
      seg_d = {~dp_mask[idx], seg7};
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomized bench for seg_scan_driver: a cycle-count reference model predicts an/seg/frame_done every clock.
module tb_seg_scan_driver;

  localparam int SD = 4;
  localparam int BD = 32;
  localparam int GD = 1;
  localparam int FR = 4 * SD;
  localparam logic [7:0] DEC [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                      8'h80, 8'h90, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] digits_in;
  logic        load;
  logic [3:0]  dp_mask;
  logic [3:0]  blink_mask;
  logic        blank_lead;
  logic [3:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int checks = 0;
  int failures = 0;

  // Model state: cycles since reset, committed/pending digits, whether a frame has committed yet.
  int          t = 0;
  logic [15:0] m_active = 16'h0;
  logic [15:0] m_pending = 16'h0;
  logic        m_live = 1'b0;

  seg_scan_driver #(.SCAN_DIV(SD), .BLINK_DIV(BD), .GUARD_CYCLES(GD)) dut (
    .clk(clk), .rst(rst), .digits_in(digits_in), .load(load), .dp_mask(dp_mask),
    .blink_mask(blink_mask), .blank_lead(blank_lead), .an(an), .seg(seg), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0d)", tag, got, want, t);
    end
  endtask

  function automatic int cur_idx();
    return (t / SD) % 4;
  endfunction

  task automatic step();
    int ix;
    logic bnd, dark;
    logic [3:0] d;
    logic [3:0] e_an;
    logic [7:0] e_seg, code;
    logic e_fd;
    ix   = cur_idx();
    bnd  = ((t % FR) == FR - 1);
    d    = m_active[ix*4 +: 4];
    code = DEC[d];
    dark = !m_live || (blink_mask[ix] && (((t / BD) % 2) == 1))
         || (blank_lead && ix == 3 && m_active[15:12] == 4'h0)
         || (blank_lead && ix == 2 && m_active[15:8] == 8'h00);
`ifdef SEG_GHOST_GUARD_EN
    if ((t % SD) < GD) dark = 1'b1;
`endif
    if (rst) begin
      e_an = 4'hF; e_seg = 8'hFF; e_fd = 1'b0;
    end else begin
      e_an  = dark ? 4'hF : ~(4'b0001 << ix);
      e_seg = dark ? 8'hFF : {~dp_mask[ix], code[6:0]};
      e_fd  = bnd;
    end
    @(posedge clk);
    #1;
    check("an", 16'(an), 16'(e_an));
    check("seg", 16'(seg), 16'(e_seg));
    check("frame_done", 16'(frame_done), 16'(e_fd));
    if (rst) begin
      t = 0; m_active = 16'h0; m_pending = 16'h0; m_live = 1'b0;
    end else begin
      if (bnd) begin
        m_active = load ? digits_in : m_pending;
        m_live   = 1'b1;
      end
      if (load) m_pending = digits_in;
      t++;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_to_phase(input int ph);
    for (int i = 0; i < FR && (t % FR) != ph; i++) step();
  endtask

  task automatic load_one(input logic [15:0] v);
    digits_in = v; load = 1'b1;
    step();
    load = 1'b0;
  endtask

  initial begin
    logic [3:0] tab_an [4];
    logic [7:0] tab_seg [4];
    logic seen;
    tab_an  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    tab_seg = '{8'h99, 8'hB0, 8'hA4, 8'hF9};

    rst = 1'b1; load = 1'b0; digits_in = 16'h0;
    dp_mask = 4'h0; blink_mask = 4'h0; blank_lead = 1'b0;
    run(2);
    rst = 1'b0;
    check("reset_an", 16'(an), 16'hF);
    check("reset_seg", 16'(seg), 16'hFF);

    // 1234: dark until the first boundary, then the fixed scan sequence.
    load_one(16'h1234);
    seen = 1'b0;
    for (int i = 0; i < 3 * FR && !seen; i++) begin
      step();
      seen = frame_done;
    end
    check("frame_done_seen", 16'(seen), 16'h1);
    for (int s = 0; s < 4; s++)
      for (int c = 0; c < SD; c++) begin
        step();
`ifndef SEG_GHOST_GUARD_EN
        check("scan_an", 16'(an), 16'(tab_an[s]));
        check("scan_seg", 16'(seg), 16'(tab_seg[s]));
`endif
      end

    // Leading-zero blanking also suppresses dp on blanked digit 2.
    blank_lead = 1'b1; dp_mask = 4'b0100;
    load_one(16'h0005);
    run(2 * FR);
    blank_lead = 1'b0; dp_mask = 4'h0;

    // Mid-frame load is never shown; boundary load takes the bypass.
    run_to_phase(SD + 1);
    load_one(16'h5959);
    run_to_phase(FR - 1);
    load_one(16'h0000);
    run(FR + 4);

    blink_mask = 4'b0011;
    load_one(16'h1200);
    run(5 * BD);
    blink_mask = 4'h0;

    load_one(16'h00A0);
    run(2 * FR);

    // Reset while idx=2, then restart with a fresh load.
    run_to_phase(2 * SD + 1);
    rst = 1'b1; load = 1'b1; digits_in = 16'h8888;
    step();
    rst = 1'b0; load = 1'b0;
    check("rst_frame_done", 16'(frame_done), 16'h0);
    load_one(16'h0000);
    run(2 * FR + 3);

    for (int i = 0; i < 2500; i++) begin
      rst        = ($urandom_range(0, 299) == 0);
      load       = ($urandom_range(0, 3) == 0);
      digits_in  = 16'($urandom);
      if ($urandom_range(0, 1) == 0) digits_in[15:8] = 8'h00;
      if ($urandom_range(0, 15) == 0) begin
        dp_mask    = 4'($urandom);
        blink_mask = 4'($urandom);
        blank_lead = 1'($urandom);
      end
      step();
    end
    rst = 1'b0; load = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
